// File: rtl/ss_bus_master.sv
// Save-state sequencer: walks every slave on the save-state bus, streaming each slave's
// words out on save and writing a header-framed stream back into the slaves on load.
module ss_bus_master #(
  parameter int NUM_SLAVES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_start,
  input  logic        load_start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        ssb_access,
  output logic [7:0]  ssb_select,
  output logic        ssb_query,
  output logic        ssb_read,
  output logic        ssb_write,
  output logic [23:0] ssb_addr,
  output logic [63:0] ssb_data,
  input  logic        ssb_ack,
  input  logic [63:0] ssb_data_out
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]      IDX_LAST = 8'(NUM_SLAVES - 1);

  typedef enum logic [3:0] {
    IDLE, S_QUERY, S_HDR, S_READ, S_OUT, S_NEXT, S_DONE,
    L_HDR, L_WORD, L_WRITE, L_NEXT, L_DONE, L_ERR
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         idx;
  logic [31:0]        cnt;
  logic [31:0]        wcnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [63:0]        out_data_q;
  logic [63:0]        wdata;
  logic               error_q;
  logic               req_end;
  logic               last_word;
  logic               last_idx;
  logic               hdr_mismatch;

  // An ack on the final timeout cycle still wins over the timeout.
  assign req_end      = ssb_ack || (tmo_cnt == TMO_LAST);
  assign last_word    = (wcnt + 32'd1) == cnt;
  assign last_idx     = (idx == IDX_LAST);
  assign hdr_mismatch = (in_data[63:56] != idx);

  assign out_data   = out_data_q;
  assign error      = error_q;
  assign ssb_select = idx;
  assign ssb_addr   = wcnt[23:0];
  assign ssb_data   = wdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    out_valid  = 1'b0;
    in_ready   = 1'b0;
    ssb_query  = 1'b0;
    ssb_read   = 1'b0;
    ssb_write  = 1'b0;
    ssb_access = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (save_start)      state_nxt = S_QUERY;
        else if (load_start) state_nxt = L_HDR;
      end
      S_QUERY: begin
        ssb_query = 1'b1;
        if (req_end) state_nxt = S_HDR;
      end
      S_HDR: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (cnt == 32'd0) ? S_NEXT : S_READ;
      end
      S_READ: begin
        ssb_read = 1'b1;
        if (req_end) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_word ? S_NEXT : S_READ;
      end
      S_NEXT: state_nxt = last_idx ? S_DONE : S_QUERY;
      S_DONE, L_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      L_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (hdr_mismatch)              state_nxt = L_ERR;
          else if (in_data[31:0] == 0)   state_nxt = L_NEXT;
          else                           state_nxt = L_WORD;
        end
      end
      L_WORD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = L_WRITE;
      end
      L_WRITE: begin
        ssb_write = 1'b1;
        if (req_end) state_nxt = last_word ? L_NEXT : L_WORD;
      end
      L_NEXT: state_nxt = last_idx ? L_DONE : L_HDR;
      L_ERR: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    ssb_access = ssb_query | ssb_read | ssb_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      cnt        <= '0;
      wcnt       <= '0;
      tmo_cnt    <= '0;
      out_data_q <= '0;
      wdata      <= '0;
      error_q    <= 1'b0;
    end else begin
      // Every request is followed by an idle cycle, so clearing here restarts the count per request.
      tmo_cnt <= (ssb_access && !req_end) ? tmo_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (save_start || load_start) begin
            idx     <= '0;
            error_q <= 1'b0;
          end
        end
        S_QUERY: begin
          if (req_end) begin
            cnt        <= ssb_ack ? ssb_data_out[31:0] : 32'd0;
            out_data_q <= {idx, 24'h0, (ssb_ack ? ssb_data_out[31:0] : 32'd0)};
            wcnt       <= '0;
          end
        end
        S_READ: begin
          if (req_end) out_data_q <= ssb_ack ? ssb_data_out : 64'd0;
        end
        S_OUT: begin
          if (out_ready) wcnt <= wcnt + 32'd1;
        end
        S_NEXT, L_NEXT: begin
          if (!last_idx) idx <= idx + 8'd1;
        end
        L_HDR: begin
          if (in_valid) begin
            cnt  <= in_data[31:0];
            wcnt <= '0;
            if (hdr_mismatch) error_q <= 1'b1;
          end
        end
        L_WORD: begin
          if (in_valid) wdata <= in_data;
        end
        L_WRITE: begin
          if (req_end) wcnt <= wcnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_bus_master.sv
// Scoreboard bench for ss_bus_master: a behavioural slave bus model plus save/load stream
// models derived from the slave table, checked by independent monitor processes.
module tb_ss_bus_master;
  localparam int NS  = 16;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset, save_start, load_start;
  logic        busy, done, error, out_valid, out_ready, in_valid, in_ready;
  logic [63:0] out_data, in_data, ssb_data, ssb_data_out;
  logic        ssb_access, ssb_query, ssb_read, ssb_write, ssb_ack;
  logic [7:0]  ssb_select;
  logic [23:0] ssb_addr;

  always #5 clk = ~clk;

  ss_bus_master #(.NUM_SLAVES(NS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .save_start(save_start), .load_start(load_start),
    .busy(busy), .done(done), .error(error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ssb_access(ssb_access), .ssb_select(ssb_select), .ssb_query(ssb_query),
    .ssb_read(ssb_read), .ssb_write(ssb_write), .ssb_addr(ssb_addr),
    .ssb_data(ssb_data), .ssb_ack(ssb_ack), .ssb_data_out(ssb_data_out)
  );

  int checks = 0;
  int errors = 0;

  // Slave table: latency -2 = random 0..3 cycles, -1 = never acks, N = ack after N waiting cycles.
  int          size [NS];
  int          qlat [NS];
  int          rlat [NS];
  int          wlat [NS];
  logic [63:0] mem  [NS][8];

  logic [63:0] exp_q  [$];
  logic [63:0] in_q   [$];
  logic [95:0] exp_wr [$];
  int          rdy_mode    = 0;
  int          done_cnt    = 0;
  bit          in_rdy_seen = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int l);
    return (l == -2) ? int'($urandom_range(0, 3)) : l;
  endfunction

  function automatic bit lat_ok(input int l);
    return (l != -1) && (l < TMO);
  endfunction

  // Save stream: header per slave with the count it reports (0 if it never answers), then its words.
  function automatic void save_model();
    for (int i = 0; i < NS; i++) begin
      int c;
      c = lat_ok(qlat[i]) ? size[i] : 0;
      exp_q.push_back({8'(i), 24'h0, 32'(c)});
      for (int a = 0; a < c; a++) exp_q.push_back(lat_ok(rlat[i]) ? mem[i][a] : 64'h0);
    end
  endfunction

  function automatic void load_model();
    for (int i = 0; i < NS; i++) begin
      in_q.push_back({8'(i), 24'h0, 32'(size[i])});
      for (int a = 0; a < size[i]; a++) begin
        in_q.push_back(mem[i][a]);
        if (lat_ok(wlat[i])) exp_wr.push_back({8'(i), 24'(a), mem[i][a]});
      end
    end
  endfunction

  task automatic cfg_absent();
    for (int i = 0; i < NS; i++) begin
      size[i] = 0; qlat[i] = -1; rlat[i] = -1; wlat[i] = -1;
      for (int a = 0; a < 8; a++) mem[i][a] = {$urandom, $urandom};
    end
  endtask

  task automatic cfg_basic();
    cfg_absent();
    size[0] = 3; qlat[0] = -2; rlat[0] = -2; wlat[0] = -2;
  endtask

  task automatic cfg_random();
    for (int i = 0; i < NS; i++) begin
      size[i] = $urandom_range(0, 5);
      qlat[i] = ($urandom_range(0, 3) == 0) ? -1 : -2;
      rlat[i] = ($urandom_range(0, 5) == 0) ? -1 : -2;
      wlat[i] = ($urandom_range(0, 5) == 0) ? -1 : -2;
      for (int a = 0; a < 8; a++) mem[i][a] = {$urandom, $urandom};
    end
  endtask

  // Slave bus model: acks, returns query/read data, and checks every acked write against exp_wr.
  initial begin
    int  wait_c, tgt, s, a, nstb;
    bit  in_req, prev_ack;
    ssb_ack = 1'b0; ssb_data_out = '0;
    in_req = 0; prev_ack = 0; wait_c = 0; tgt = -1; s = 0;
    forever begin
      @(negedge clk);
      ssb_ack = 1'b0;
      if (prev_ack && !reset) check("bus_gap_after_ack", {95'h0, ssb_access}, 96'h0);
      prev_ack = 0;
      if (reset || !ssb_access) begin
        in_req = 0;
      end else begin
        if (!in_req) begin
          in_req = 1; wait_c = 0; s = ssb_select;
          nstb = int'(ssb_query) + int'(ssb_read) + int'(ssb_write);
          check("one_strobe", 96'(nstb), 96'd1);
          if (s >= NS)        tgt = -1;
          else if (ssb_query) tgt = pick(qlat[s]);
          else if (ssb_read)  tgt = pick(rlat[s]);
          else                tgt = pick(wlat[s]);
        end
        if (tgt >= 0 && wait_c == tgt) begin
          ssb_ack = 1'b1; prev_ack = 1;
          a = ssb_addr;
          if (ssb_query)     ssb_data_out = 64'(size[s]);
          else if (ssb_read) ssb_data_out = (a < 8) ? mem[s][a] : 64'h0;
          else if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: idx %0d addr %0d data %0h, none expected", s, a, ssb_data);
          end else begin
            check("write", {ssb_select, ssb_addr, ssb_data}, exp_wr.pop_front());
          end
        end
        wait_c++;
      end
    end
  end

  // Stream monitor/driver: out_ready pattern, save scoreboard, hold check, load stream source.
  initial begin
    bit          stall;
    logic [63:0] held;
    int          cyc;
    stall = 0; held = '0; cyc = 0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (in_ready) in_rdy_seen = 1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset) begin
        stall = 0;
      end else begin
        if (stall) check("out_hold", {31'h0, out_valid, out_data}, {32'h1, held});
        if (out_valid) begin
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL extra_out_word: got %0h, none expected", out_data);
            end else begin
              check("out_word", 96'(out_data), 96'(exp_q.pop_front()));
            end
            stall = 0;
          end else begin
            stall = 1; held = out_data;
          end
        end else begin
          stall = 0;
        end
      end
      if (in_q.size() > 0 && !reset) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = in_q[0];
        if (in_valid && in_ready) void'(in_q.pop_front());
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  task automatic pulse_save();
    @(negedge clk); save_start = 1'b1;
    @(negedge clk); save_start = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 30000) begin
      @(negedge clk); n++;
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
    end
    repeat (4) @(negedge clk);
    check({name, "_done_once"}, 96'(done_cnt - d0), 96'd1);
    check({name, "_busy_low"}, {95'h0, busy}, 96'h0);
  endtask

  task automatic run_save(input string name, input int mode);
    int d0;
    rdy_mode = mode; d0 = done_cnt;
    save_model();
    pulse_save();
    check({name, "_busy_high"}, {95'h0, busy}, 96'h1);
    wait_done(name, d0);
    check({name, "_stream_drained"}, 96'(exp_q.size()), 96'd0);
  endtask

  task automatic run_load(input string name);
    int d0;
    d0 = done_cnt;
    load_model();
    pulse_load();
    check({name, "_busy_high"}, {95'h0, busy}, 96'h1);
    wait_done(name, d0);
    check({name, "_writes_drained"}, 96'(exp_wr.size()), 96'd0);
    check({name, "_input_drained"}, 96'(in_q.size()), 96'd0);
  endtask

  initial begin
    int d0, n;
    reset = 1'b1; save_start = 1'b0; load_start = 1'b0;
    cfg_basic();
    repeat (3) @(negedge clk);
    check("reset_ctrl", {90'h0, busy, done, error, out_valid, in_ready, ssb_access}, 96'h0);
    check("reset_strobes", {93'h0, ssb_query, ssb_read, ssb_write}, 96'h0);
    check("reset_sel_addr", {64'h0, ssb_select, ssb_addr}, 96'h0);
    check("reset_data", {ssb_data, 32'h0}, 96'h0);
    check("reset_out_data", 96'(out_data), 96'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_save("save_basic", 0);
    run_save("save_stall", 1);
    run_load("load_basic");

    // Timeout boundary: ack on the last allowed cycle counts, one cycle later does not.
    cfg_absent();
    size[1] = 2; qlat[1] = TMO - 1; rlat[1] = TMO;
    size[2] = 4; qlat[2] = TMO;     rlat[2] = -2;
    size[3] = 3; qlat[3] = -2;      rlat[3] = TMO - 1;
    run_save("save_tmo", 2);
    size[2] = 0; wlat[1] = TMO; wlat[3] = TMO - 1;
    run_load("load_tmo");

    cfg_random();
    run_save("save_rand", 2);
    run_load("load_rand");

    // Header index 5 where 4 is expected.
    cfg_absent();
    wlat[1] = -2;
    in_q.push_back({8'd0, 24'h0, 32'd0});
    in_q.push_back({8'd1, 24'h0, 32'd1});
    in_q.push_back(mem[1][0]);
    exp_wr.push_back({8'd1, 24'd0, mem[1][0]});
    in_q.push_back({8'd2, 24'h0, 32'd0});
    in_q.push_back({8'd3, 24'h0, 32'd0});
    in_q.push_back({8'd5, 24'h0, 32'd2});
    in_q.push_back(64'h1111);
    in_q.push_back(64'h2222);
    wlat[5] = -2; wlat[4] = -2;
    d0 = done_cnt;
    pulse_load();
    n = 0;
    while (!error && n < 2000) begin
      @(negedge clk); n++;
    end
    check("mismatch_error", {94'h0, error, busy}, 96'h2);
    repeat (30) @(negedge clk);
    check("mismatch_sticky", {93'h0, error, busy, in_ready}, 96'h4);
    check("mismatch_no_done", 96'(done_cnt - d0), 96'd0);
    check("mismatch_writes", 96'(exp_wr.size()), 96'd0);
    in_q.delete();

    // Simultaneous starts: save wins; pulses while busy are ignored; error clears.
    cfg_basic();
    rdy_mode = 0; d0 = done_cnt;
    save_model();
    @(negedge clk); save_start = 1'b1; load_start = 1'b1;
    @(negedge clk); save_start = 1'b0; load_start = 1'b0;
    in_rdy_seen = 0;
    check("both_error_cleared", {94'h0, error, busy}, 96'h1);
    repeat (5) @(negedge clk);
    pulse_load();
    repeat (3) @(negedge clk);
    pulse_save();
    wait_done("both", d0);
    check("both_no_in_ready", {95'h0, in_rdy_seen}, 96'h0);
    check("both_stream_drained", 96'(exp_q.size()), 96'd0);
    repeat (10) @(negedge clk);
    check("both_idle_after", {94'h0, busy, done}, 96'h0);

    // Reset while a read is outstanding, then a fresh save from slave 0.
    cfg_basic();
    size[0] = 5; rlat[0] = 3;
    save_model();
    pulse_save();
    n = 0;
    while (!ssb_read && n < 500) begin
      @(negedge clk); n++;
    end
    check("reached_read", {95'h0, ssb_read}, 96'h1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_idle", {90'h0, ssb_access, ssb_query, ssb_read, ssb_write, out_valid, busy}, 96'h0);
    reset = 1'b0;
    exp_q.delete();
    run_save("save_after_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
